// File: rtl/fast_ring_fetch.sv
// FAST ring read sequencer: fetches the center pixel and its radius-3 Bresenham ring
// through the 1-cycle-latency image SRAM read port and presents all 17 values in parallel.
module fast_ring_fetch #(
  parameter int PIXEL_DEPTH = 8,
  parameter int X_MAX       = 64,
  parameter int Y_MAX       = 64,
  parameter int XW          = $clog2(X_MAX),
  parameter int YW          = $clog2(Y_MAX)
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      start,
  input  logic [XW-1:0]             cx,
  input  logic [YW-1:0]             cy,
  output logic                      busy,
  output logic                      done,
  output logic [PIXEL_DEPTH-1:0]    center_px,
  output logic [16*PIXEL_DEPTH-1:0] ring_px,
  output logic                      border,
  output logic [XW-1:0]             x_addr,
  output logic [YW-1:0]             y_addr,
  output logic                      ren,
  output logic                      wen,
  input  logic [PIXEL_DEPTH-1:0]    rdat
);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN, ST_DONE} state_t;

  localparam logic [XW+1:0] X_LIM = (XW+2)'(X_MAX);
  localparam logic [YW+1:0] Y_LIM = (YW+2)'(Y_MAX);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [4:0]             r_idx;
  logic [XW-1:0]          r_cx;
  logic [YW-1:0]          r_cy;
  logic                   r_cap_pend;
  logic                   r_rd_issued;
  logic [4:0]             r_cap_idx;
  logic                   r_border;
  logic [PIXEL_DEPTH-1:0] r_center;
  logic [PIXEL_DEPTH-1:0] r_ring [16];

  logic signed [2:0]      w_dx;
  logic signed [2:0]      w_dy;
  logic [XW+1:0]          w_x;
  logic [YW+1:0]          w_y;
  logic                   w_inb;
  logic                   w_accept;
  logic [3:0]             w_slot;
  logic [PIXEL_DEPTH-1:0] w_cap_data;

  always_comb begin
    w_dx = 3'sd0;
    w_dy = 3'sd0;
    case (r_idx)
      5'd1:  begin w_dx =  3'sd0; w_dy = -3'sd3; end
      5'd2:  begin w_dx =  3'sd1; w_dy = -3'sd3; end
      5'd3:  begin w_dx =  3'sd2; w_dy = -3'sd2; end
      5'd4:  begin w_dx =  3'sd3; w_dy = -3'sd1; end
      5'd5:  begin w_dx =  3'sd3; w_dy =  3'sd0; end
      5'd6:  begin w_dx =  3'sd3; w_dy =  3'sd1; end
      5'd7:  begin w_dx =  3'sd2; w_dy =  3'sd2; end
      5'd8:  begin w_dx =  3'sd1; w_dy =  3'sd3; end
      5'd9:  begin w_dx =  3'sd0; w_dy =  3'sd3; end
      5'd10: begin w_dx = -3'sd1; w_dy =  3'sd3; end
      5'd11: begin w_dx = -3'sd2; w_dy =  3'sd2; end
      5'd12: begin w_dx = -3'sd3; w_dy =  3'sd1; end
      5'd13: begin w_dx = -3'sd3; w_dy =  3'sd0; end
      5'd14: begin w_dx = -3'sd3; w_dy = -3'sd1; end
      5'd15: begin w_dx = -3'sd2; w_dy = -3'sd2; end
      5'd16: begin w_dx = -3'sd1; w_dy = -3'sd3; end
      default: ;
    endcase
  end

  // Two guard bits make a negative coordinate wrap to a large unsigned value,
  // so a single unsigned compare against the image size covers both edges.
  assign w_x   = {2'b00, r_cx} + {{(XW-1){w_dx[2]}}, w_dx};
  assign w_y   = {2'b00, r_cy} + {{(YW-1){w_dy[2]}}, w_dy};
  assign w_inb = (w_x < X_LIM) && (w_y < Y_LIM);

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // The done cycle also samples start so back-to-back fetches run every 19 cycles.
  always_comb begin
    // NOTE: every output is defaulted first so no path through the case infers a latch.
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    ren         = 1'b0;
    x_addr      = '0;
    y_addr      = '0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        busy   = 1'b1;
        ren    = w_inb;
        x_addr = w_inb ? w_x[XW-1:0] : r_cx;
        y_addr = w_inb ? w_y[YW-1:0] : r_cy;
        if (r_idx == 5'd16) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy        = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_slot     = 4'(r_cap_idx - 5'd1);
  assign w_cap_data = r_rd_issued ? rdat : '0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_idx       <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_cap_pend  <= 1'b0;
      r_rd_issued <= 1'b0;
      r_cap_idx   <= '0;
      r_border    <= 1'b0;
      r_center    <= '0;
      // NOTE: the slot bank is reset like any flop because its value is visible on ring_px.
      for (int k = 0; k < 16; k++) r_ring[k] <= '0;
    end else begin
      r_cap_pend  <= (r_state == ST_FETCH);
      r_rd_issued <= ren;
      r_cap_idx   <= r_idx;
      if (r_state == ST_FETCH) begin
        r_idx <= r_idx + 5'd1;
        if (!w_inb) r_border <= 1'b1;
      end
      if (r_cap_pend) begin
        if (r_cap_idx == 5'd0) r_center       <= w_cap_data;
        else                   r_ring[w_slot] <= w_cap_data;
      end
      if (w_accept) begin
        r_cx     <= cx;
        r_cy     <= cy;
        r_idx    <= '0;
        r_border <= 1'b0;
        r_center <= '0;
        for (int k = 0; k < 16; k++) r_ring[k] <= '0;
      end
    end
  end

  always_comb begin
    ring_px = '0;
    for (int k = 0; k < 16; k++) ring_px[k*PIXEL_DEPTH +: PIXEL_DEPTH] = r_ring[k];
  end

  assign center_px = r_center;
  assign border    = r_border;
  assign wen       = 1'b0;

endmodule
